// File: rtl/fe_fifo_arbiter.sv
// Two-requester write arbiter for the front-end capture FIFO: per-source queues,
// round-robin grant, TIME-packet lock, saturating drop counters, sticky overflow.
module fe_fifo_arbiter #(
    parameter int unsigned pTIME_WIDTH = 16,
    parameter int unsigned pDEPTH      = 4,
    parameter int unsigned pDROP_WIDTH = 16,
    parameter logic [1:0]  pCMD_TIME   = 2'd2
) (
    input  logic                   fe_clk,
    input  logic                   reset_n,
    input  logic                   I_arm,
    input  logic                   I_a_wr,
    input  logic [pTIME_WIDTH-1:0] I_a_time,
    input  logic [1:0]             I_a_cmd,
    input  logic                   I_b_wr,
    input  logic [pTIME_WIDTH-1:0] I_b_time,
    input  logic [1:0]             I_b_cmd,
    input  logic                   I_fifo_full,
    output logic                   O_fifo_wr,
    output logic [pTIME_WIDTH-1:0] O_fifo_time,
    output logic [1:0]             O_fifo_cmd,
    output logic                   O_fifo_src,
    output logic [pDROP_WIDTH-1:0] O_a_drops,
    output logic [pDROP_WIDTH-1:0] O_b_drops,
    output logic                   O_overflow
);

    localparam int unsigned AW = $clog2(pDEPTH);
    localparam int unsigned EW = pTIME_WIDTH + 2;

    logic                arm_r;
    logic                arm_rise;
    logic                last_grant;
    logic                lock_on;
    logic                lock_src;
    logic                sel;
    logic                pop;
    logic [1:0]          ne;
    logic [1:0]          full;
    logic [1:0]          wr;
    logic [1:0]          pop_s;
    logic [1:0]          push_ok;
    logic [1:0]          drop;
    logic [1:0][EW-1:0]  din;
    logic [1:0][EW-1:0]  head;
    logic [EW-1:0]       pop_entry;

    assign arm_rise = I_arm & ~arm_r;
    assign wr       = {I_b_wr, I_a_wr};
    assign din[0]   = {I_a_time, I_a_cmd};
    assign din[1]   = {I_b_time, I_b_cmd};

    for (genvar g = 0; g < 2; g++) begin : g_q
        logic [EW-1:0] mem [pDEPTH];
        logic [AW-1:0] wptr;
        logic [AW-1:0] rptr;
        logic [AW:0]   cnt;

        always_ff @(posedge fe_clk) begin
            if (push_ok[g]) mem[wptr] <= din[g];
        end

        always_ff @(posedge fe_clk or negedge reset_n) begin
            if (!reset_n) begin
                wptr <= '0;
                rptr <= '0;
                cnt  <= '0;
            end else if (arm_rise) begin
                wptr <= '0;
                rptr <= '0;
                cnt  <= '0;
            end else begin
                if (push_ok[g]) wptr <= wptr + 1'b1;
                if (pop_s[g])   rptr <= rptr + 1'b1;
                if (push_ok[g] && !pop_s[g])      cnt <= cnt + 1'b1;
                else if (!push_ok[g] && pop_s[g]) cnt <= cnt - 1'b1;
            end
        end

        // Power-of-2 depth: the count MSB is set only when the queue is full.
        assign ne[g]   = |cnt;
        assign full[g] = cnt[AW];
        assign head[g] = mem[rptr];
    end

    always_comb begin
        sel = last_grant;
        if (lock_on && ne[lock_src])  sel = lock_src;
        else if (ne[0] && !ne[1])     sel = 1'b0;
        else if (!ne[0] && ne[1])     sel = 1'b1;
        else                          sel = ~last_grant;
        pop       = ~I_fifo_full & (|ne) & ~arm_rise;
        pop_s     = pop ? (sel ? 2'b10 : 2'b01) : 2'b00;
        push_ok   = wr & (~full | pop_s) & {2{~arm_rise}};
        drop      = wr & ~(~full | pop_s) & {2{~arm_rise}};
        pop_entry = head[sel];
    end

    always_ff @(posedge fe_clk or negedge reset_n) begin
        if (!reset_n) begin
            arm_r       <= 1'b0;
            last_grant  <= 1'b1;
            lock_on     <= 1'b0;
            lock_src    <= 1'b0;
            O_fifo_wr   <= 1'b0;
            O_fifo_time <= '0;
            O_fifo_cmd  <= '0;
            O_fifo_src  <= 1'b0;
            O_a_drops   <= '0;
            O_b_drops   <= '0;
            O_overflow  <= 1'b0;
        end else begin
            arm_r <= I_arm;
            if (arm_rise) begin
                last_grant <= 1'b1;
                lock_on    <= 1'b0;
                lock_src   <= 1'b0;
                O_fifo_wr  <= 1'b0;
                O_a_drops  <= '0;
                O_b_drops  <= '0;
                O_overflow <= 1'b0;
            end else begin
                O_fifo_wr <= pop;
                if (pop) begin
                    O_fifo_time <= pop_entry[EW-1:2];
                    O_fifo_cmd  <= pop_entry[1:0];
                    O_fifo_src  <= sel;
                    last_grant  <= sel;
                    // A TIME pop pins the next grant to the same source.
                    if (pop_entry[1:0] == pCMD_TIME) begin
                        lock_on  <= 1'b1;
                        lock_src <= sel;
                    end else begin
                        lock_on  <= 1'b0;
                    end
                end else if (lock_on && !ne[lock_src]) begin
                    lock_on <= 1'b0;
                end
                if (drop[0] && O_a_drops != '1) O_a_drops <= O_a_drops + 1'b1;
                if (drop[1] && O_b_drops != '1) O_b_drops <= O_b_drops + 1'b1;
                if (|drop) O_overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fe_fifo_arbiter.sv
// Bench for fe_fifo_arbiter: directed scenarios plus random traffic, checked each
// cycle against a queue-based reference model.
module tb_fe_fifo_arbiter;

    localparam int         TW   = 16;
    localparam int         D    = 4;
    localparam int         DW   = 16;
    localparam logic [1:0] CT   = 2'd2;
    localparam int         MAXD = (1 << DW) - 1;

    logic          fe_clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          I_arm = 1'b0;
    logic          I_a_wr = 1'b0;
    logic [TW-1:0] I_a_time = '0;
    logic [1:0]    I_a_cmd = '0;
    logic          I_b_wr = 1'b0;
    logic [TW-1:0] I_b_time = '0;
    logic [1:0]    I_b_cmd = '0;
    logic          I_fifo_full = 1'b0;
    logic          O_fifo_wr;
    logic [TW-1:0] O_fifo_time;
    logic [1:0]    O_fifo_cmd;
    logic          O_fifo_src;
    logic [DW-1:0] O_a_drops;
    logic [DW-1:0] O_b_drops;
    logic          O_overflow;

    always #5 fe_clk = ~fe_clk;

    fe_fifo_arbiter #(
        .pTIME_WIDTH(TW),
        .pDEPTH     (D),
        .pDROP_WIDTH(DW),
        .pCMD_TIME  (CT)
    ) dut (
        .fe_clk     (fe_clk),
        .reset_n    (reset_n),
        .I_arm      (I_arm),
        .I_a_wr     (I_a_wr),
        .I_a_time   (I_a_time),
        .I_a_cmd    (I_a_cmd),
        .I_b_wr     (I_b_wr),
        .I_b_time   (I_b_time),
        .I_b_cmd    (I_b_cmd),
        .I_fifo_full(I_fifo_full),
        .O_fifo_wr  (O_fifo_wr),
        .O_fifo_time(O_fifo_time),
        .O_fifo_cmd (O_fifo_cmd),
        .O_fifo_src (O_fifo_src),
        .O_a_drops  (O_a_drops),
        .O_b_drops  (O_b_drops),
        .O_overflow (O_overflow)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference model: one queue per source, spec rules applied per clock edge.
    typedef struct packed {
        logic [TW-1:0] t;
        logic [1:0]    c;
    } ent_t;

    ent_t qa[$];
    ent_t qb[$];
    int   m_drops [2];
    bit   m_ovf, m_lock, m_arm_prev, m_wr;
    int   m_lock_src, m_last, m_src;
    ent_t m_out;

    int log_t[$];
    int log_c[$];
    int log_s[$];

    function automatic void model_reset();
        qa.delete();
        qb.delete();
        m_drops    = '{0, 0};
        m_ovf      = 0;
        m_lock     = 0;
        m_lock_src = 0;
        m_last     = 1;
        m_arm_prev = 0;
        m_wr       = 0;
        m_out      = '0;
        m_src      = 0;
    endfunction

    function automatic void model_step();
        bit   rise, pop;
        int   na, nb, sel;
        ent_t e;
        rise       = I_arm && !m_arm_prev;
        m_arm_prev = I_arm;
        if (rise) begin
            qa.delete();
            qb.delete();
            m_drops = '{0, 0};
            m_ovf   = 0;
            m_lock  = 0;
            m_last  = 1;
            m_wr    = 0;
            return;
        end
        na  = qa.size();
        nb  = qb.size();
        pop = !I_fifo_full && (na > 0 || nb > 0);
        if (m_lock && ((m_lock_src == 0 && na > 0) || (m_lock_src == 1 && nb > 0))) sel = m_lock_src;
        else if (na > 0 && nb == 0) sel = 0;
        else if (nb > 0 && na == 0) sel = 1;
        else sel = 1 - m_last;
        if (pop) begin
            e      = (sel == 0) ? qa.pop_front() : qb.pop_front();
            m_out  = e;
            m_src  = sel;
            m_last = sel;
            if (e.c == CT) begin
                m_lock     = 1;
                m_lock_src = sel;
            end else begin
                m_lock = 0;
            end
        end else if (m_lock && ((m_lock_src == 0 && na == 0) || (m_lock_src == 1 && nb == 0))) begin
            m_lock = 0;
        end
        m_wr = pop;
        if (I_a_wr) begin
            if (na < D || (pop && sel == 0)) qa.push_back(ent_t'{t: I_a_time, c: I_a_cmd});
            else begin
                if (m_drops[0] < MAXD) m_drops[0]++;
                m_ovf = 1;
            end
        end
        if (I_b_wr) begin
            if (nb < D || (pop && sel == 1)) qb.push_back(ent_t'{t: I_b_time, c: I_b_cmd});
            else begin
                if (m_drops[1] < MAXD) m_drops[1]++;
                m_ovf = 1;
            end
        end
    endfunction

    task automatic tick();
        if (!reset_n) model_reset();
        else model_step();
        @(posedge fe_clk);
        #1;
        chk("wr", O_fifo_wr, m_wr);
        chk("time", O_fifo_time, m_out.t);
        chk("cmd", O_fifo_cmd, m_out.c);
        chk("src", O_fifo_src, m_src);
        chk("a_drops", O_a_drops, m_drops[0]);
        chk("b_drops", O_b_drops, m_drops[1]);
        chk("overflow", O_overflow, m_ovf);
        if (O_fifo_wr) begin
            log_t.push_back(int'(O_fifo_time));
            log_c.push_back(int'(O_fifo_cmd));
            log_s.push_back(int'(O_fifo_src));
        end
    endtask

    task automatic drive(input bit aw, input int at, input int ac, input bit bw, input int bt, input int bc);
        I_a_wr   = aw;
        I_a_time = TW'(at);
        I_a_cmd  = 2'(ac);
        I_b_wr   = bw;
        I_b_time = TW'(bt);
        I_b_cmd  = 2'(bc);
        tick();
    endtask

    task automatic idle(input int n);
        I_a_wr = 0;
        I_b_wr = 0;
        repeat (n) tick();
    endtask

    task automatic arm_pulse();
        I_arm = 1;
        tick();
        I_arm = 0;
    endtask

    task automatic clear_log();
        log_t.delete();
        log_c.delete();
        log_s.delete();
    endtask

    function automatic int at(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_wr"}, O_fifo_wr, 0);
        chk({tag, "_time"}, O_fifo_time, 0);
        chk({tag, "_cmd"}, O_fifo_cmd, 0);
        chk({tag, "_src"}, O_fifo_src, 0);
        chk({tag, "_adrops"}, O_a_drops, 0);
        chk({tag, "_bdrops"}, O_b_drops, 0);
        chk({tag, "_ovf"}, O_overflow, 0);
    endtask

    initial begin
        model_reset();
        reset_n = 0;
        repeat (2) tick();
        chk_zero_outputs("reset");
        reset_n = 1;

        // Single source, 2-cycle latency.
        clear_log();
        drive(1, 5, 0, 0, 0, 0);
        chk("lat_cycle1", O_fifo_wr, 0);
        drive(1, 6, 0, 0, 0, 0);
        chk("lat_cycle2", O_fifo_wr, 1);
        drive(1, 7, 0, 0, 0, 0);
        idle(3);
        chk("single_count", log_t.size(), 3);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("single_time%0d", i), at(log_t, i), 5 + i);
            chk($sformatf("single_src%0d", i), at(log_s, i), 0);
        end
        chk("single_drops", O_a_drops, 0);

        // Round-robin with both queues preloaded.
        arm_pulse();
        I_fifo_full = 1;
        for (int i = 0; i < 3; i++) drive(1, 10 + i, 0, 1, 20 + i, 1);
        I_fifo_full = 0;
        clear_log();
        idle(6);
        chk("rr_count", log_s.size(), 6);
        for (int i = 0; i < 6; i++) chk($sformatf("rr_src%0d", i), at(log_s, i), i % 2);

        // TIME lock keeps A's following entry adjacent.
        arm_pulse();
        I_fifo_full = 1;
        drive(1, 100, CT, 1, 50, 0);
        drive(1, 3, 1, 1, 51, 0);
        I_fifo_full = 0;
        clear_log();
        idle(5);
        chk("lock_count", log_s.size(), 4);
        chk("lock_s0", at(log_s, 0), 0);
        chk("lock_t0", at(log_t, 0), 100);
        chk("lock_c0", at(log_c, 0), CT);
        chk("lock_s1", at(log_s, 1), 0);
        chk("lock_t1", at(log_t, 1), 3);
        chk("lock_c1", at(log_c, 1), 1);
        chk("lock_s2", at(log_s, 2), 1);
        chk("lock_t2", at(log_t, 2), 50);
        chk("lock_s3", at(log_s, 3), 1);
        chk("lock_t3", at(log_t, 3), 51);

        // Overflow on B while FIFO full.
        arm_pulse();
        I_fifo_full = 1;
        for (int i = 0; i < 6; i++) drive(0, 0, 0, 1, 200 + i, 3);
        idle(1);
        chk("ovf_bdrops", O_b_drops, 2);
        chk("ovf_flag", O_overflow, 1);
        chk("ovf_adrops", O_a_drops, 0);
        I_fifo_full = 0;
        clear_log();
        idle(5);
        chk("ovf_count", log_t.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("ovf_time%0d", i), at(log_t, i), 200 + i);
            chk($sformatf("ovf_src%0d", i), at(log_s, i), 1);
        end

        // Arm with entries queued and drops pending; push during arm is discarded.
        arm_pulse();
        I_fifo_full = 1;
        for (int i = 0; i < 6; i++) drive(0, 0, 0, 1, 210 + i, 0);
        chk("arm_pre_drops", O_b_drops, 2);
        I_b_wr = 1;
        I_b_time = 16'd999;
        arm_pulse();
        chk("arm_wr", O_fifo_wr, 0);
        I_fifo_full = 0;
        clear_log();
        idle(4);
        chk("arm_nowrites", log_t.size(), 0);
        chk("arm_bdrops", O_b_drops, 0);
        chk("arm_ovf", O_overflow, 0);

        // Push to a full queue accepted when the same queue pops.
        arm_pulse();
        I_fifo_full = 1;
        for (int i = 0; i < 4; i++) drive(1, 20 + i, 0, 0, 0, 0);
        I_fifo_full = 0;
        clear_log();
        drive(1, 24, 0, 0, 0, 0);
        chk("simul_drops", O_a_drops, 0);
        I_fifo_full = 1;
        drive(1, 25, 0, 0, 0, 0);
        idle(1);
        chk("simul_full_drop", O_a_drops, 1);
        I_fifo_full = 0;
        idle(6);
        chk("simul_count", log_t.size(), 5);
        for (int i = 0; i < 5; i++) chk($sformatf("simul_time%0d", i), at(log_t, i), 20 + i);

        // Random traffic with an asynchronous reset mid-burst.
        arm_pulse();
        for (int i = 0; i < 400; i++) begin
            I_a_wr      = ($urandom_range(0, 2) != 0);
            I_a_time    = TW'($urandom);
            I_a_cmd     = 2'($urandom_range(0, 3));
            I_b_wr      = ($urandom_range(0, 2) != 0);
            I_b_time    = TW'($urandom);
            I_b_cmd     = 2'($urandom_range(0, 3));
            I_fifo_full = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 49) == 0) I_arm = ~I_arm;
            if (i == 200) begin
                #2;
                reset_n = 0;
                #1;
                chk_zero_outputs("async_reset");
                tick();
                tick();
                reset_n = 1;
            end
            tick();
        end
        idle(6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fe_fifo_arbiter.md
# fe_fifo_arbiter

Two-requester write arbiter for the front-end capture FIFO. It sits between the FIFO write port and two event producers. Requester A is the main front-end capture engine. Requester B is an auxiliary source, such as trigger-edge or marker stamps. Each requester gets a small per-source queue, and grants to the single FIFO write port are round-robin. A TIME packet is never separated from the entry that follows it. Per-source drops are counted and a sticky overflow flag is kept, both cleared on each arm.

## Interface
Parameters:
- pTIME_WIDTH, 16, width of the timestamp field.
- pDEPTH, 4, entries per source queue; must be a power of 2, minimum 2.
- pDROP_WIDTH, 16, width of each drop counter.
- pCMD_TIME, 2'd2, command code that marks a TIME packet.

Ports:
- fe_clk  in  1  front-end clock; the only clock.
- reset_n  in  1  asynchronous, active-low reset.
- I_arm  in  1  arm level; a rising edge re-initialises the block.
- I_a_wr  in  1  requester A write strobe.
- I_a_time  in  pTIME_WIDTH  requester A timestamp.
- I_a_cmd  in  2  requester A command.
- I_b_wr, I_b_time, I_b_cmd  in  1 / pTIME_WIDTH / 2  same fields for requester B.
- I_fifo_full  in  1  downstream FIFO full.
- O_fifo_wr  out  1  FIFO write strobe; registered.
- O_fifo_time  out  pTIME_WIDTH  registered write data.
- O_fifo_cmd  out  2  registered write command.
- O_fifo_src  out  1  source of the written entry; 0 = A, 1 = B.
- O_a_drops, O_b_drops  out  pDROP_WIDTH  drop counters; saturating.
- O_overflow  out  1  sticky; set on any drop.

## Operation
- Each source queue stores {time, cmd} as a FIFO of pDEPTH entries with a count of width log2(pDEPTH)+1.
- Push: a source's write strobe is accepted when its count < pDEPTH, or when that source is popped in the same cycle.
- Drop: if a push is not accepted, the entry is discarded, the source's drop counter increments (saturating at all-ones), and O_overflow sets.
- Grant: a pop happens only when I_fifo_full = 0 and at least one queue is non-empty. At most one pop occurs per cycle.
- Selection order:
  1. Lock. The lock is set to source X in a cycle in which X's pCMD_TIME entry is popped. While it is set and X is non-empty, grant X. The lock clears after one grant cycle, or whenever X is empty.
  2. Only one queue non-empty: grant that queue.
  3. Both non-empty: grant the source not in last_grant.
- Register last_grant updates on every pop.
- Output register: at each edge, O_fifo_wr = pop, and O_fifo_time/cmd/src take the popped entry. When there is no pop, data holds its value and O_fifo_wr = 0.
- Arm rising edge, detected against an internal arm_r register:
  - both queues empty; any push in that cycle is discarded and not counted;
  - drop counters = 0, O_overflow = 0;
  - lock cleared, last_grant = B, so A wins the first tie;
  - O_fifo_wr = 0 next cycle.
- reset_n low (asynchronous): every register returns to 0, except last_grant = B.
  - All outputs read 0.
  - Queue contents are discarded.
  - Operation resumes on the first edge after release.

## Timing
- Latency with an empty queue and FIFO not full: write strobe in cycle 0 -> O_fifo_wr high in cycle 2.
- Throughput: one FIFO write per cycle, sustained, shared between both sources.
- I_fifo_full is sampled combinationally in the grant cycle. A full in cycle n blocks the pop in cycle n, so no O_fifo_wr in cycle n+1.
- Lock applies to the cycle immediately after the TIME pop, so a TIME packet and its following entry are written on consecutive cycles when the FIFO is not full.
- If the FIFO stalls between them, the lock persists until the following entry is popped.
- Drop counters and O_overflow update one edge after the rejected strobe.

## Test plan
- Single source: A pushes cmd 0, times 5, 6, 7 on cycles 0-2 -> O_fifo_wr in cycles 2-4 with times 5, 6, 7, src 0; O_a_drops = 0.
- Round-robin: both queues preloaded with 3 entries each, FIFO not full -> output src sequence A, B, A, B, A, B.
- TIME lock:
  - A holds {TIME, t=100} then {cmd 1, t=3}; B holds 2 entries; first grant is A.
  - Required output order: A:TIME/100, A:1/3, B, B.
- Overflow: I_fifo_full = 1, B pushes 6 entries with pDEPTH = 4 -> O_b_drops = 2 and O_overflow = 1.
  - Release full -> 4 writes, src 1, in push order.
- Arm and reset:
  - Arm edge with entries queued and drops = 2 -> no further writes; counters 0; overflow 0.
  - reset_n pulsed low mid-burst -> outputs 0 immediately, before any edge.
- Simultaneous push/pop: A queue at count 4, FIFO not full, new A write in the same cycle -> accepted, count stays 4, no drop.
